wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//   Multi-cycle, multi-precision add/subtract controller around one shared Adder_32bit.
//   Accepts WORDS*32-bit operands on a valid/ready handshake.
//   Feeds one 32-bit word per cycle, least-significant word first, with the carry registered between words.
//   Presents the full-width result on a held valid/ready output.
//   Gives wide (e.g. 128-bit) arithmetic without replicating the 32-bit carry-lookahead datapath.
// PARAMETERS
//   WORDS  4  number of 32-bit words per operand (>=1); operand width N = 32*WORDS
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   in_valid   in   1   operand request valid
//   in_ready   out  1   block can accept operands
//   in_a       in   N   operand A
//   in_b       in   N   operand B
//   in_cin     in   1   carry-in (add mode only)
//   in_sub     in   1   1 = A - B, 0 = A + B + in_cin
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer takes result
//   out_sum    out  N   result
//   out_cout   out  1   final carry (subtract: 1 = no borrow)
//   busy       out  1   high in RUN or DONE
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0.
//     - Word index and carry register cleared.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//     - IDLE: in_ready=1. On in_valid&in_ready:
//         - latch A; latch B (B inverted if in_sub); idx=0.
//         - carry=in_sub ? 1 : in_cin; go to RUN.
//     - RUN: in_ready=0. Each cycle the adder computes A[idx]+B[idx]+carry.
//         - Sum word written to out_sum[32*idx +: 32]; carry<=c_out; idx++.
//         - When idx==WORDS-1: out_cout<=c_out; go to DONE.
//     - DONE: out_valid=1; out_sum/out_cout held stable while out_ready=0.
//         - On out_ready: out_valid<=0, go to IDLE.
//   Latency:
//     - Accept at edge T -> out_valid high after edge T+WORDS.
//     - Throughput one op per WORDS+2 cycles (one IDLE cycle between ops; no accept in DONE).
//   Operand and mode captured at accept; input changes during RUN/DONE are ignored.
//   out_sum is only meaningful while out_valid=1; partially written words may be visible during RUN.
//   Width rules:
//     - All arithmetic modulo 2^N; carry passes only between successive words.
//     - No overflow flag; signed overflow is the consumer's job.
//   WORDS=1: single RUN cycle; identical to one Adder_32bit op plus registering.
//   Simultaneous events: in_valid is ignored outside IDLE (in_ready=0); no queuing.
//   Reset mid-operation (RUN or DONE): result discarded, all outputs to reset values immediately.
//   No X propagation: unused adder inputs in IDLE are driven from the registered operands.
// TESTING
//   (WORDS=4 unless noted)
//   1. A=2^128-1, B=1, add, cin=0 -> out_sum=0, out_cout=1; out_valid 4 cycles after accept.
//   2. A=0x0000_0000_FFFF_FFFF, B=0, cin=1 -> out_sum=0x1_0000_0000 (carry across word 0/1 boundary), cout=0.
//   3. Subtract A=0, B=1 -> out_sum=2^128-1, cout=0; A=5, B=3 -> out_sum=2, cout=1.
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_sum/out_valid stable.
//      - in_valid pulses ignored (in_ready=0).
//      - After out_ready: IDLE next cycle, in_ready=1.
//   5. Deassert rst_n in RUN at idx=2 -> out_valid=0, out_sum=0, in_ready=1 asynchronously.
//      - Next op after release gives a correct result.
//   6. Random back-to-back ops, WORDS=1 and WORDS=4, vs 128-bit reference model.
//      - Covers in_sub and in_cin combinations; scoreboard checks every sum, cout and latency.

Source files
------------

// File: rtl/wide_add_sequencer_if.sv
// Handshake bundle for wide_add_sequencer: operand request side and held result side.
// The master drives operands and takes results; the slave is the sequencer itself.
interface wide_add_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int N = 32 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract: one shared 32-bit carry-lookahead adder stepped
// over WORDS operand words, least-significant first, with a registered carry.

module Adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [8:0]  gc;

    // Eight 4-bit lookahead groups; group carries chain through gc.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        gc    = '0;
        gc[0] = c_in;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
            gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        c[32] = gc[8];
        sum   = p ^ c[31:0];
        c_out = c[32];
    end
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wide_add_sequencer_if.slave  bus
);
    localparam int N     = 32 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [N-1:0]     out_sum_q;
    logic             out_cout_q;

    logic [31:0]      a_word;
    logic [31:0]      b_word;
    logic [31:0]      adder_sum;
    logic             adder_cout;

    // Word select always reads registered operands, so the adder never sees X.
    always_comb begin
        a_word = a_reg[31:0];
        b_word = b_reg[31:0];
        for (int w = 0; w < WORDS; w++) begin
            if (idx == w[IDX_W-1:0]) begin
                a_word = a_reg[32*w +: 32];
                b_word = b_reg[32*w +: 32];
            end
        end
    end

    Adder_32bit u_adder (
        .a     (a_word),
        .b     (b_word),
        .c_in  (carry),
        .sum   (adder_sum),
        .c_out (adder_cout)
    );

    // Subtraction is folded in at accept time: B is inverted and carry preset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_reg      <= bus.in_a;
                        b_reg      <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carry      <= bus.in_sub ? 1'b1 : bus.in_cin;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == w[IDX_W-1:0]) begin
                            out_sum_q[32*w +: 32] <= adder_sum;
                        end
                    end
                    carry <= adder_cout;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        out_cout_q  <= adder_cout;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer at WORDS=4 and WORDS=1
// against an independent full-width arithmetic model.
module tb_wide_add_sequencer;
    logic clk;
    logic rst_n;
    int   tests;
    int   failures;

    wide_add_sequencer_if #(.WORDS(4)) bus4 ();
    wide_add_sequencer_if #(.WORDS(1)) bus1 ();

    wide_add_sequencer #(.WORDS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    wide_add_sequencer #(.WORDS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] a;
        logic [127:0] b;
        logic         cin;
        logic         sub;
        logic [127:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic rdy(input bit narrow);
        return narrow ? bus1.in_ready : bus4.in_ready;
    endfunction

    function automatic logic vld(input bit narrow);
        return narrow ? bus1.out_valid : bus4.out_valid;
    endfunction

    function automatic logic bsy(input bit narrow);
        return narrow ? bus1.busy : bus4.busy;
    endfunction

    // Reference: plain full-width arithmetic, borrow taken from a magnitude compare.
    function automatic void model(input bit narrow, input logic [127:0] a, input logic [127:0] b,
                                  input logic cin, input logic sub,
                                  output logic [127:0] s, output logic c);
        logic [32:0]  f32;
        logic [128:0] f128;
        if (narrow) begin
            if (sub) begin
                s = {96'b0, a[31:0] - b[31:0]};
                c = (a[31:0] >= b[31:0]);
            end else begin
                f32 = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'b0, cin};
                s   = {96'b0, f32[31:0]};
                c   = f32[32];
            end
        end else begin
            if (sub) begin
                s = a - b;
                c = (a >= b);
            end else begin
                f128 = {1'b0, a} + {1'b0, b} + {128'b0, cin};
                s    = f128[127:0];
                c    = f128[128];
            end
        end
    endfunction

    task automatic applyStimulus(input bit narrow, input logic [127:0] a, input logic [127:0] b,
                                 input logic cin, input logic sub, output int lat,
                                 output logic [127:0] sum, output logic cout);
        bit ok;
        @(negedge clk);
        bus4.in_a = a;        bus4.in_b = b;        bus4.in_cin = cin; bus4.in_sub = sub;
        bus1.in_a = a[31:0];  bus1.in_b = b[31:0];  bus1.in_cin = cin; bus1.in_sub = sub;
        if (narrow) bus1.in_valid = 1'b1;
        else        bus4.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rdy(narrow)) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) reportTimeout("in_ready");
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        checkOutput("busy after accept", {127'b0, bsy(narrow)}, 128'd1);
        checkOutput("in_ready during run", {127'b0, rdy(narrow)}, 128'd0);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1;
            lat++;
            ok = vld(narrow);
        end
        if (!ok) reportTimeout("out_valid");
        sum  = narrow ? {96'b0, bus1.out_sum} : bus4.out_sum;
        cout = narrow ? bus1.out_cout : bus4.out_cout;
    endtask

    task automatic finishOp(input bit narrow);
        @(negedge clk);
        if (narrow) bus1.out_ready = 1'b1;
        else        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        bus4.out_ready = 1'b0;
        checkOutput("out_valid after take", {127'b0, vld(narrow)}, 128'd0);
        checkOutput("in_ready after take", {127'b0, rdy(narrow)}, 128'd1);
    endtask

    task automatic runVector(input string name, input bit narrow, input logic [127:0] a,
                             input logic [127:0] b, input logic cin, input logic sub,
                             input logic [127:0] exp_sum, input logic exp_cout);
        int           lat;
        logic [127:0] sum;
        logic         cout;
        applyStimulus(narrow, a, b, cin, sub, lat, sum, cout);
        checkOutput({name, " sum"}, sum, exp_sum);
        checkOutput({name, " cout"}, {127'b0, cout}, {127'b0, exp_cout});
        checkOutput({name, " latency"}, 128'(lat), narrow ? 128'd1 : 128'd4);
        finishOp(narrow);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic         stable;
        logic [127:0] rs;
        logic         rc;
        logic [127:0] ra;
        logic [127:0] rb;
        bit           rn;

        tests    = 0;
        failures = 0;

        vecs[0] = '{name: "all-ones plus one", a: {128{1'b1}}, b: 128'd1, cin: 1'b0, sub: 1'b0,
                    exp_sum: 128'd0, exp_cout: 1'b1};
        vecs[1] = '{name: "carry word0 to word1", a: 128'h0000_0000_FFFF_FFFF, b: 128'd0, cin: 1'b1,
                    sub: 1'b0, exp_sum: 128'h1_0000_0000, exp_cout: 1'b0};
        vecs[2] = '{name: "sub 0-1", a: 128'd0, b: 128'd1, cin: 1'b0, sub: 1'b1,
                    exp_sum: {128{1'b1}}, exp_cout: 1'b0};
        vecs[3] = '{name: "sub 5-3", a: 128'd5, b: 128'd3, cin: 1'b0, sub: 1'b1,
                    exp_sum: 128'd2, exp_cout: 1'b1};
        vecs[4] = '{name: "msb overflow", a: 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                    b: 128'h8000_0000_0000_0000_0000_0000_0000_0000, cin: 1'b0, sub: 1'b0,
                    exp_sum: 128'd0, exp_cout: 1'b1};
        vecs[5] = '{name: "sub equal cin ignored", a: 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                    b: 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, cin: 1'b1, sub: 1'b1,
                    exp_sum: 128'd0, exp_cout: 1'b1};
        vecs[6] = '{name: "carry ripple to word3", a: 128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                    b: 128'd0, cin: 1'b1, sub: 1'b0,
                    exp_sum: 128'h0000_0002_0000_0000_0000_0000_0000_0000, exp_cout: 1'b0};

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0;
        bus4.in_sub = 1'b0;   bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0;
        bus1.in_sub = 1'b0;   bus1.out_ready = 1'b0;
        #12;
        checkOutput("reset in_ready", {127'b0, bus4.in_ready}, 128'd1);
        checkOutput("reset out_valid", {127'b0, bus4.out_valid}, 128'd0);
        checkOutput("reset out_sum", bus4.out_sum, 128'd0);
        checkOutput("reset out_cout", {127'b0, bus4.out_cout}, 128'd0);
        checkOutput("reset busy", {127'b0, bus4.busy}, 128'd0);
        checkOutput("reset w1 in_ready", {127'b0, bus1.in_ready}, 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            runVector(vecs[i].name, 1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                      vecs[i].exp_sum, vecs[i].exp_cout);
        end

        runVector("w1 wrap", 1'b1, 128'hFFFF_FFFF, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1);
        runVector("w1 sub 3-5", 1'b1, 128'd3, 128'd5, 1'b0, 1'b1, 128'hFFFF_FFFE, 1'b0);

        // Backpressure: result must hold and new requests must be refused.
        begin
            int lat;
            applyStimulus(1'b0, 128'd5, 128'd3, 1'b0, 1'b1, lat, rs, rc);
            stable = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                bus4.in_a     = 128'hDEAD;
                bus4.in_valid = i[0];
                if (!bus4.out_valid || bus4.out_sum !== 128'd2 || !bus4.out_cout || bus4.in_ready)
                    stable = 1'b0;
            end
            @(negedge clk);
            bus4.in_valid = 1'b0;
            checkOutput("backpressure stable", {127'b0, stable}, 128'd1);
            finishOp(1'b0);
            checkOutput("busy back in idle", {127'b0, bus4.busy}, 128'd0);
            repeat (3) @(negedge clk);
            checkOutput("ignored pulse not accepted", {127'b0, bus4.busy}, 128'd0);
        end

        // Reset in the middle of RUN, with partial words already written.
        @(negedge clk);
        bus4.in_a = {4{32'h1111_1111}};
        bus4.in_b = {4{32'h2222_2222}};
        bus4.in_cin = 1'b0;
        bus4.in_sub = 1'b0;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset out_valid", {127'b0, bus4.out_valid}, 128'd0);
        checkOutput("midrun reset out_sum", bus4.out_sum, 128'd0);
        checkOutput("midrun reset in_ready", {127'b0, bus4.in_ready}, 128'd1);
        checkOutput("midrun reset busy", {127'b0, bus4.busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runVector("after reset", 1'b0, {4{32'h1111_1111}}, {4{32'h2222_2222}}, 1'b0, 1'b0,
                  {4{32'h3333_3333}}, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rn = ($urandom_range(0, 2) == 0);
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (i % 5 == 0) rb = ~ra;
            model(rn, ra, rb, i[0], i[1], rs, rc);
            runVector("random", rn, ra, rb, i[0], i[1], rs, rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
